// File: rtl/board_uart_dumper_pkg.sv
// Shared constants and FSM state type for the board UART dumper.
// Character codes and the dump sequencer states.
package board_dump_pkg;

    localparam logic [7:0] CH_ALIVE = 8'h23;
    localparam logic [7:0] CH_DEAD  = 8'h2E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT_DATA,
        SEND_CELL,
        SEND_CR,
        SEND_LF,
        FINISH
    } dump_state_t;

    function automatic logic [7:0] cell_char(input logic alive);
        return alive ? CH_ALIVE : CH_DEAD;
    endfunction

endpackage

// File: rtl/board_uart_dumper_if.sv
// Board memory read port: the dumper issues strobed reads, memory answers a cycle later.
interface board_uart_dumper_if #(
    parameter int w_x = 7,
    parameter int w_y = 6
);
    logic           cell_rd;
    logic [w_x-1:0] cell_x;
    logic [w_y-1:0] cell_y;
    logic           cell_alive;

    modport master (output cell_rd, output cell_x, output cell_y, input cell_alive);
    modport slave  (input cell_rd, input cell_x, input cell_y, output cell_alive);
endinterface

// File: rtl/board_uart_dumper_uart_tx_byte.sv
// 8N1 UART transmitter, LSB first; accepts one byte whenever idle.
module uart_tx_byte #(
    parameter int clks_per_bit = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx
);

    localparam int w_cnt = $clog2(clks_per_bit + 1);
    localparam logic [w_cnt-1:0] cnt_last = w_cnt'(clks_per_bit - 1);

    logic             active;
    logic [w_cnt-1:0] bit_cnt;
    logic [3:0]       bit_idx;
    logic [8:0]       shreg;

    assign tx_ready = !active;

    // Bit index 0 is the start bit; the stop bit is shifted in as the ninth bit of shreg.
    always_ff @(posedge clk) begin
        if (!rst) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '1;
            uart_tx <= 1'b1;
        end else if (!active) begin
            if (tx_valid) begin
                active  <= 1'b1;
                uart_tx <= 1'b0;
                shreg   <= {1'b1, tx_data};
                bit_cnt <= '0;
                bit_idx <= '0;
            end
        end else if (bit_cnt == cnt_last) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
                active <= 1'b0;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                uart_tx <= shreg[0];
                shreg   <= {1'b1, shreg[8:1]};
            end
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_uart_dumper.sv
// Streams the Game of Life board over UART as '#'/'.' characters, one CR LF per row.
module board_uart_dumper
    import board_dump_pkg::*;
#(
    parameter int clk_mhz = 50,
    parameter int baud    = 115200,
    parameter int board_w = 80,
    parameter int board_h = 60,
    parameter int w_x     = $clog2(board_w),
    parameter int w_y     = $clog2(board_h)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                uart_tx,
    board_uart_dumper_if.master mem
);

    localparam int clks_per_bit = (clk_mhz * 1000000 + baud / 2) / baud;
    localparam logic [w_x-1:0] x_last = w_x'(board_w - 1);
    localparam logic [w_y-1:0] y_last = w_y'(board_h - 1);

    dump_state_t    state;
    logic [w_x-1:0] x;
    logic [w_y-1:0] y;
    logic           rd_q;
    logic [7:0]     cell_byte;
    logic           tx_valid;
    logic           tx_ready;
    logic [7:0]     tx_data;

    assign mem.cell_rd = rd_q;
    assign mem.cell_x  = x;
    assign mem.cell_y  = y;

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = cell_byte;
        case (state)
            SEND_CELL: tx_valid = 1'b1;
            SEND_CR: begin
                tx_valid = 1'b1;
                tx_data  = CH_CR;
            end
            SEND_LF: begin
                tx_valid = 1'b1;
                tx_data  = CH_LF;
            end
            default: ;
        endcase
    end

    // The read strobe is raised on the edge entering READ so it is high for exactly that cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_q      <= 1'b0;
            x         <= '0;
            y         <= '0;
            cell_byte <= CH_DEAD;
        end else begin
            done <= 1'b0;
            rd_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        x     <= '0;
                        y     <= '0;
                        busy  <= 1'b1;
                        rd_q  <= 1'b1;
                        state <= READ;
                    end
                end
                READ: state <= WAIT_DATA;
                WAIT_DATA: begin
                    cell_byte <= cell_char(mem.cell_alive);
                    state     <= SEND_CELL;
                end
                SEND_CELL: begin
                    if (tx_ready) begin
                        if (x < x_last) begin
                            x     <= x + 1'b1;
                            rd_q  <= 1'b1;
                            state <= READ;
                        end else begin
                            state <= SEND_CR;
                        end
                    end
                end
                SEND_CR: if (tx_ready) state <= SEND_LF;
                SEND_LF: begin
                    if (tx_ready) begin
                        x <= '0;
                        if (y < y_last) begin
                            y     <= y + 1'b1;
                            rd_q  <= 1'b1;
                            state <= READ;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    if (tx_ready) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_tx_byte #(.clks_per_bit(clks_per_bit)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .uart_tx  (uart_tx)
    );

endmodule

// File: tb/tb_board_uart_dumper.sv
// Self-checking bench: 4x2 board, 4 clocks per bit, UART decoded and compared against a board model.
module tb_board_uart_dumper;

    localparam int BW = 4;
    localparam int BH = 2;
    localparam int CPB = 4;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
    logic uart_tx;
    logic [7:0] board_bits;

    board_uart_dumper_if #(.w_x(2), .w_y(1)) bus ();

    board_uart_dumper #(
        .clk_mhz (1),
        .baud    (250000),
        .board_w (BW),
        .board_h (BH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .uart_tx (uart_tx),
        .mem     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board memory: answers one cycle after the read strobe
    always @(posedge clk) begin
        bus.cell_alive <= bus.cell_rd ? board_bits[{bus.cell_y, bus.cell_x}] : 1'b0;
    end

    int compare_count = 0;
    int mismatch_count = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         addr_q[$];
    int         exp_addr_q[$];
    bit         mon_active = 0;
    bit         in_gap = 0;
    int         gap_cnt = 0;
    int         max_gap = 0;
    int         hold_err = 0;
    int         frame_err = 0;
    int         done_cnt = 0;
    int         early_done = 0;
    int         busy_low = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART line monitor: captures 40 samples per frame and decodes them
    initial begin
        logic [39:0] smp;
        int n;
        logic [7:0] b;
        n = 0;
        smp = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_active = 0;
                in_gap = 0;
                n = 0;
            end else if (mon_active) begin
                smp[n] = uart_tx;
                n++;
                if (n == 10 * CPB) begin
                    for (int bi = 0; bi < 10; bi++)
                        for (int k = 1; k < CPB; k++)
                            if (smp[bi*CPB+k] !== smp[bi*CPB]) hold_err++;
                    if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) frame_err++;
                    for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*CPB];
                    rx_q.push_back(b);
                    mon_active = 0;
                    in_gap = 1;
                    gap_cnt = 0;
                end
            end else if (uart_tx == 1'b0) begin
                if (in_gap && gap_cnt > max_gap) max_gap = gap_cnt;
                in_gap = 0;
                mon_active = 1;
                smp[0] = 1'b0;
                n = 1;
            end else if (in_gap) begin
                gap_cnt++;
            end
        end
    end

    // Read-strobe and done monitors
    initial begin
        forever begin
            @(negedge clk);
            if (rst && bus.cell_rd) addr_q.push_back(int'(bus.cell_y) * 16 + int'(bus.cell_x));
            if (rst && done) begin
                done_cnt++;
                if (rx_q.size() != exp_q.size() || mon_active) early_done++;
            end
        end
    end

    task automatic buildModel(input logic [7:0] pattern);
        exp_q.delete();
        exp_addr_q.delete();
        for (int yy = 0; yy < BH; yy++) begin
            for (int xx = 0; xx < BW; xx++) begin
                exp_q.push_back(pattern[yy*BW+xx] ? 8'h23 : 8'h2E);
                exp_addr_q.push_back(yy * 16 + xx);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pattern, input bit poke_starts);
        bit got_done;
        board_bits = pattern;
        buildModel(pattern);
        rx_q.delete();
        addr_q.delete();
        done_cnt = 0; early_done = 0; hold_err = 0; frame_err = 0;
        max_gap = 0; in_gap = 0; busy_low = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        got_done = 0;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                if (poke_starts) start = 1'b1;
            end else begin
                if (!busy) busy_low++;
                start = (poke_starts && c == 150);
            end
        end
        @(negedge clk) start = 1'b0;
        checkOutput("done_seen", 32'(got_done), 32'd1);
        repeat (150) @(negedge clk);
        checkOutput("byte_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            checkOutput($sformatf("byte%0d", i), (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp_q[i]));
        checkOutput("rd_count", addr_q.size(), exp_addr_q.size());
        for (int i = 0; i < exp_addr_q.size(); i++)
            checkOutput($sformatf("addr%0d", i), (i < addr_q.size()) ? addr_q[i] : -1, exp_addr_q[i]);
        checkOutput("busy_held", busy_low, 0);
        checkOutput("done_pulses", done_cnt, 1);
        checkOutput("done_after_stop", early_done, 0);
        checkOutput("bit_hold", hold_err, 0);
        checkOutput("start_stop_bits", frame_err, 0);
        checkOutput("gap_le_3", 32'(max_gap <= 3), 32'd1);
        checkOutput("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        bit seen_start;
        rst = 1'b0;
        start = 1'b0;
        board_bits = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_cell_rd", 32'(bus.cell_rd), 32'd0);
        checkOutput("rst_cell_xy", {bus.cell_y, bus.cell_x}, 32'd0);
        rst = 1'b1;
        $display("[TB] full dump, pattern 1010/0001 with extra starts");
        applyStimulus(8'b1000_0101, 1'b1);
        for (int r = 0; r < 2; r++) begin
            $display("[TB] random board dump %0d", r);
            applyStimulus(8'($urandom), 1'b0);
        end
        $display("[TB] reset during third data bit");
        board_bits = 8'($urandom);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen_start = 0;
        for (int c = 0; c < 200 && !seen_start; c++) begin
            @(negedge clk);
            if (uart_tx == 1'b0) seen_start = 1;
        end
        checkOutput("midrst_frame_began", 32'(seen_start), 32'd1);
        repeat (13) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_cell_rd", 32'(bus.cell_rd), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'b1000_0101, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule

// File: doc/board_uart_dumper.md
Name: board_uart_dumper

Overview:
- Streams the current Game of Life board to a host over UART 8N1, one ASCII character per cell.
- Alive cells are sent as '#' (0x23) and dead cells as '.' (0x2E), each row terminated by CR LF.
- Sits beside game_top in the board top level, drives uart_tx, and reads cells through the board memory's read port.
- Dump is triggered by a start pulse, for example from a debounced key.

Parameters:
- clk_mhz, 50: system clock frequency in MHz.
- baud, 115200: UART bit rate.
- board_w, 80: cells per row.
- board_h, 60: rows per board.
- w_x, $clog2(board_w): cell column address width.
- w_y, $clog2(board_h): cell row address width.
- Derived localparam clks_per_bit = (clk_mhz*1000000 + baud/2) / baud; the defaults give 434.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- busy  output  1  high from the cycle after start is accepted until the done pulse.
- done  output  1  one-cycle pulse after the stop bit of the final LF completes.
- cell_rd  output  1  one-cycle read strobe to board memory.
- cell_x  output  w_x  column address, valid while cell_rd is high.
- cell_y  output  w_y  row address, valid while cell_rd is high.
- cell_alive  input  1  cell state; valid exactly one cycle after cell_rd.
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Reset (rst low at an edge):
  - Outputs go to busy=0, done=0, cell_rd=0, cell_x=0, cell_y=0, uart_tx=1.
  - This applies even mid-frame; the partial frame is truncated and no resume occurs.
- Main FSM states: IDLE, READ, WAIT_DATA, SEND_CELL, SEND_CR, SEND_LF, FINISH.
- IDLE: start=1 moves to READ with x=0, y=0 and busy=1.
- READ: drive cell_rd=1 with cell_x=x and cell_y=y, then go to WAIT_DATA.
- WAIT_DATA: sample cell_alive, form the byte (0x23 if 1, 0x2E if 0), go to SEND_CELL.
- SEND_CELL: offer the byte to the serializer and hold until accepted. Then:
  - x < board_w-1: increment x, go to READ.
  - otherwise: go to SEND_CR.
- SEND_CR: offer 0x0D; on acceptance go to SEND_LF.
- SEND_LF: offer 0x0A; on acceptance, x=0. Then:
  - y < board_h-1: increment y, go to READ.
  - otherwise: go to FINISH.
- FINISH: wait until the serializer is idle (stop bit complete), pulse done for one cycle, clear busy, return to IDLE.
- Counter wrap: x and y wrap only via these explicit compares. No address ever exceeds board_w-1 or board_h-1.
- Bytes per dump: exactly board_h*(board_w+2).
- Serializer (8N1, LSB first):
  - It accepts a byte on the cycle tx_valid && tx_ready, with tx_ready high only when idle.
  - The start bit (0) begins on the next cycle, followed by d0..d7 and then the stop bit (1).
  - Each bit lasts exactly clks_per_bit cycles, so a frame is 10*clks_per_bit cycles.
- Inter-frame gap: between the end of one stop bit and the next start bit, 0 to 3 idle-high cycles (FSM read overhead).
- start during busy: ignored, not queued. A start in the same cycle as done is also ignored.
- Board memory: cell_alive is not sampled outside WAIT_DATA. The board may change during a dump; no snapshot is taken.

Decomposition:
- Package board_dump_pkg holds:
  - char constants: CH_ALIVE=8'h23, CH_DEAD=8'h2E, CH_CR=8'h0D, CH_LF=8'h0A;
  - the FSM state enum type.
- Sub-module uart_tx_byte:
  - parameter clks_per_bit;
  - ports clk, rst, tx_data[7:0], tx_valid, tx_ready, uart_tx;
  - implemented as a bit-period counter, bit index, and shift register.

Test Plan:
- Tests use clk_mhz=1, baud=250000 (clks_per_bit=4), board_w=4, board_h=2. The memory model returns cell_alive one cycle after cell_rd.
- Reset: hold rst=0 for 3 cycles -> uart_tx=1, busy=0, done=0, cell_rd=0.
- Full dump, pattern row0=1010 and row1=0001:
  - decoded bytes are 23 2E 23 2E 0D 0A 2E 2E 2E 23 0D 0A;
  - busy stays high throughout;
  - exactly one done pulse occurs, after the final stop bit.
- Frame timing: for byte 0x23, the line reads 0,1,1,0,0,0,1,0,0,1, each bit held 4 cycles; measured frame = 40 cycles; gaps between frames are 0 to 3 cycles.
- Addressing: the cell_rd sequence is (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1) with exactly 8 strobes, and no address is ever >= board limits.
- start asserted again mid-dump, and on the done cycle -> ignored: still 12 bytes total and no second dump.
- Reset mid-frame during the 3rd data bit -> uart_tx=1 on the next cycle, busy=0. A new start then produces a complete 12-byte dump beginning at (0,0).
